laplacian_frame_sched: RTL

- Frame-level controller for the 3x3 `laplacian` core.
- Walks a frame in raster order. For every output pixel it:
  - reads the 3x3 neighbourhood from a single-port frame RAM,
  - presents the window to the core and waits for `sonuc_done`,
  - writes the result to the output RAM.
- Border pixels are written as zero without invoking the core.
- Replaces ad-hoc bench sequencing with a synthesizable scheduler between the pixel RAM, the core and the result RAM.

---
 rtl/laplacian_frame_sched.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/laplacian_frame_sched.sv
// laplacian_frame_sched
//   Frame-level scheduler for the 3x3 laplacian core. It walks the frame in
//   raster order. For each interior pixel it fetches the 3x3 neighbourhood
//   from the pixel RAM, fires the core, waits for its result and writes that
//   result to the result RAM. Border pixels are written as zero and never
//   reach the core.
//
// Optional feature macro: LAPLACIAN_SCHED_ABS_CLAMP_EN
//   defined   : the core result is stored as |res| saturated to 255,
//               zero-extended to RES_W
//   undefined : the core result is stored unchanged (signed RES_W)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   start_i      start one frame (accepted only in IDLE)
//   busy_o       frame in progress
//   done_o       one-cycle pulse after the last write
//   rd_en_o      pixel RAM read strobe
//   rd_addr_o    pixel RAM address
//   rd_data_i    pixel RAM data, one cycle after rd_en_o
//   win_o        3x3 window, tap k at [k*PIX_W +: PIX_W], row-major
//   core_en_o    core start pulse
//   core_res_i   core result (signed)
//   core_done_i  core result valid
//   wr_en_o      result RAM write strobe
//   wr_addr_o    result RAM address (row*IMG_W+col)
//   wr_data_o    result RAM data
module laplacian_frame_sched #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8,
    parameter int RES_W  = 9
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_en_o,
    output logic [ADDR_W-1:0]       rd_addr_o,
    input  logic [PIX_W-1:0]        rd_data_i,
    output logic [9*PIX_W-1:0]      win_o,
    output logic                    core_en_o,
    input  logic signed [RES_W-1:0] core_res_i,
    input  logic                    core_done_i,
    output logic                    wr_en_o,
    output logic [ADDR_W-1:0]       wr_addr_o,
    output logic [RES_W-1:0]        wr_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0]  col_q, col_d;
    logic [3:0]         tap_q, tap_d;   // fetch cycle 0..9
    logic [1:0]         tr_q, tr_d;     // window row of the tap being read
    logic [1:0]         tc_q, tc_d;     // window column of the tap being read
    logic [9*PIX_W-1:0] win_q, win_d;
    logic [RES_W-1:0]   res_q, res_d;

`ifdef LAPLACIAN_SCHED_ABS_CLAMP_EN
    // One extra bit so that |most-negative| is representable before saturation.
    function automatic logic [RES_W-1:0] abs_clamp(input logic signed [RES_W-1:0] r);
        logic [RES_W:0] mag;
        if (r[RES_W-1])
            mag = ~{1'b1, r} + (RES_W+1)'(1);
        else
            mag = {1'b0, r};
        if (mag > (RES_W+1)'(255))
            return RES_W'(255);
        return mag[RES_W-1:0];
    endfunction
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            tr_q    <= '0;
            tc_q    <= '0;
            win_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            win_q   <= win_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tap_d     = tap_q;
        tr_d      = tr_q;
        tc_d      = tc_q;
        win_d     = win_q;
        res_d     = res_q;
        done_o    = 1'b0;
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        core_en_o = 1'b0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SEL;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            S_SEL: begin
                if (row_q == '0 || row_q == LAST_ROW || col_q == '0 || col_q == LAST_COL) begin
                    res_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    tap_d   = '0;
                    tr_d    = '0;
                    tc_d    = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // Reads are issued on cycles 0..8; each datum lands one cycle
                // later, so cycle t stores the tap requested on cycle t-1.
                if (tap_q < 4'd9) begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = (row_q + ADDR_W'(tr_q) - ONE) * W_A + col_q + ADDR_W'(tc_q) - ONE;
                    if (tc_q == 2'd2) begin
                        tc_d = 2'd0;
                        tr_d = tr_q + 2'd1;
                    end else begin
                        tc_d = tc_q + 2'd1;
                    end
                end
                for (int k = 0; k < 9; k++) begin
                    if (tap_q == 4'(k + 1))
                        win_d[k*PIX_W +: PIX_W] = rd_data_i;
                end
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd9)
                    state_d = S_ISSUE;
            end

            S_ISSUE: begin
                core_en_o = 1'b1;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                if (core_done_i) begin
`ifdef LAPLACIAN_SCHED_ABS_CLAMP_EN
                    res_d = abs_clamp(core_res_i);
`else
                    res_d = core_res_i;
`endif
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = row_q * W_A + col_q;
                wr_data_o = res_q;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + ONE;
                end else begin
                    col_d = col_q + ONE;
                end
                if (row_q == LAST_ROW && col_q == LAST_COL)
                    state_d = S_DONE;
                else
                    state_d = S_SEL;
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
    assign win_o  = win_q;

endmodule
